// File: rtl/scratchpad_arbiter_pkg.sv
// rtl/scratchpad_arbiter_pkg.sv - shared constants, types and address helper for the scratchpad arbiter
package scratchpad_arbiter_pkg;

   localparam int SCRATCH_WIDTH = 256;
   localparam int NTHREADS      = 2;

   typedef enum logic {
      PRIO_T0 = 1'b0,
      PRIO_T1 = 1'b1
   } prio_e;

   // Global address = {thread_id, local_addr}, built in a 32-bit space so callers of any
   // ADDRBITS can compare full values and slice the RAM address from the low bits.
   function automatic logic [31:0] global_addr(input logic tid,
                                               input logic [31:0] local_addr,
                                               input int unsigned addrbits);
      logic [31:0] mask;
      mask = (32'd1 << (addrbits - 1)) - 32'd1;
      return (local_addr & mask) | ({31'd0, tid} << (addrbits - 1));
   endfunction

endpackage

// File: rtl/scratchpad_arbiter_if.sv
// rtl/scratchpad_arbiter_if.sv - thread request/grant and RAM port bundle for the scratchpad arbiter
interface scratchpad_arbiter_if #(
   parameter int ADDRBITS = 10
) ();
   import scratchpad_arbiter_pkg::*;

   logic [NTHREADS-1:0]      r_req;
   logic [ADDRBITS-2:0]      r_addr0;
   logic [ADDRBITS-2:0]      r_addr1;
   logic [NTHREADS-1:0]      r_gnt;
   logic [NTHREADS-1:0]      w_req;
   logic [ADDRBITS-2:0]      w_addr0;
   logic [ADDRBITS-2:0]      w_addr1;
   logic [SCRATCH_WIDTH-1:0] w_data0;
   logic [SCRATCH_WIDTH-1:0] w_data1;
   logic [NTHREADS-1:0]      w_gnt;
   logic [NTHREADS-1:0]      rsp_valid;
   logic [SCRATCH_WIDTH-1:0] rsp_data;
   logic [ADDRBITS-1:0]      ram_raddr;
   logic [ADDRBITS-1:0]      ram_waddr;
   logic [SCRATCH_WIDTH-1:0] ram_data;
   logic                     ram_wren;
   logic [SCRATCH_WIDTH-1:0] ram_q;

   modport slave (
      input  r_req, r_addr0, r_addr1, w_req, w_addr0, w_addr1, w_data0, w_data1, ram_q,
      output r_gnt, w_gnt, rsp_valid, rsp_data, ram_raddr, ram_waddr, ram_data, ram_wren
   );

   modport master (
      output r_req, r_addr0, r_addr1, w_req, w_addr0, w_addr1, w_data0, w_data1, ram_q,
      input  r_gnt, w_gnt, rsp_valid, rsp_data, ram_raddr, ram_waddr, ram_data, ram_wren
   );

endinterface

// File: rtl/scratchpad_arbiter_rr_arb2.sv
// rtl/scratchpad_arbiter_rr_arb2.sv - two-way round-robin arbiter with per-requester block inputs
module rr_arb2
   import scratchpad_arbiter_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NTHREADS-1:0] req_i,
   input  logic [NTHREADS-1:0] block_i,
   output logic [NTHREADS-1:0] gnt_o
);

   prio_e               prio_q;
   prio_e               prio_d;
   logic [NTHREADS-1:0] elig;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q <= PRIO_T0;
      end else begin
         prio_q <= prio_d;
      end
   end

   // A blocked requester keeps its priority because prio only moves on a real grant.
   always_comb begin
      gnt_o  = '0;
      prio_d = prio_q;
      elig   = req_i & ~block_i;
      if (!rst_i) begin
         if (elig == 2'b11) begin
            gnt_o = (prio_q == PRIO_T1) ? 2'b10 : 2'b01;
         end else begin
            gnt_o = elig;
         end
      end
      if (gnt_o[0]) begin
         prio_d = PRIO_T1;
      end else if (gnt_o[1]) begin
         prio_d = PRIO_T0;
      end
   end

endmodule

// File: rtl/scratchpad_arbiter.sv
// rtl/scratchpad_arbiter.sv - shares one dual-port scrypt scratchpad RAM between two hasher threads
module scratchpad_arbiter
   import scratchpad_arbiter_pkg::*;
#(
   parameter int ADDRBITS = 10
) (
   input logic                 clock,
   input logic                 reset,
   scratchpad_arbiter_if.slave bus
);

   logic [31:0]         r_glob0;
   logic [31:0]         r_glob1;
   logic [31:0]         w_glob0;
   logic [31:0]         w_glob1;
   logic [31:0]         w_glob_sel;
   logic [NTHREADS-1:0] r_block;
   logic [NTHREADS-1:0] r_gnt;
   logic [NTHREADS-1:0] w_gnt;
   logic [NTHREADS-1:0] rsp_valid_q;
   logic [NTHREADS-1:0] rsp_valid_d;
   logic                wren;

   assign r_glob0 = global_addr(1'b0, 32'(bus.r_addr0), ADDRBITS);
   assign r_glob1 = global_addr(1'b1, 32'(bus.r_addr1), ADDRBITS);
   assign w_glob0 = global_addr(1'b0, 32'(bus.w_addr0), ADDRBITS);
   assign w_glob1 = global_addr(1'b1, 32'(bus.w_addr1), ADDRBITS);

   rr_arb2 u_wr_arb (
      .clk_i   (clock),
      .rst_i   (reset),
      .req_i   (bus.w_req),
      .block_i ('0),
      .gnt_o   (w_gnt)
   );

   assign wren       = |w_gnt;
   assign w_glob_sel = w_gnt[1] ? w_glob1 : w_glob0;

   // A read hitting the address being written this cycle waits a cycle, so read data
   // never depends on the RAM's read-during-write behaviour.
   assign r_block[0] = wren && (r_glob0 == w_glob_sel);
   assign r_block[1] = wren && (r_glob1 == w_glob_sel);

   rr_arb2 u_rd_arb (
      .clk_i   (clock),
      .rst_i   (reset),
      .req_i   (bus.r_req),
      .block_i (r_block),
      .gnt_o   (r_gnt)
   );

   assign rsp_valid_d = r_gnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_valid_q <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign bus.r_gnt     = r_gnt;
   assign bus.w_gnt     = w_gnt;
   assign bus.ram_wren  = wren;
   assign bus.ram_waddr = w_glob_sel[ADDRBITS-1:0];
   assign bus.ram_data  = w_gnt[1] ? bus.w_data1 : bus.w_data0;
   assign bus.ram_raddr = r_gnt[1] ? r_glob1[ADDRBITS-1:0] : r_glob0[ADDRBITS-1:0];
   // Responses landing while reset is high are dropped immediately.
   assign bus.rsp_valid = rsp_valid_q & ~{NTHREADS{reset}};
   assign bus.rsp_data  = bus.ram_q;

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// tb/tb_scratchpad_arbiter.sv - randomized scoreboard bench for scratchpad_arbiter
module tb_scratchpad_arbiter;
   import scratchpad_arbiter_pkg::*;

   localparam int AB   = 10;
   localparam int W    = SCRATCH_WIDTH;
   localparam int HALF = 1 << (AB - 1);

   typedef struct {
      int           due;
      int           thread;
      logic [W-1:0] data;
   } rsp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   scratchpad_arbiter_if #(.ADDRBITS(AB)) bus ();

   scratchpad_arbiter #(.ADDRBITS(AB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   logic [W-1:0] ram_mem [1 << AB];
   logic [W-1:0] ref_mem [int];
   rsp_t         sb[$];
   int           cyc = 0;
   int           vectors = 0;
   int           miscompares = 0;
   int           m_rprio = 0;
   int           m_wprio = 0;
   logic [1:0]   seen_r = 2'b00;
   logic [1:0]   seen_w = 2'b00;

   initial begin
      for (int i = 0; i < (1 << AB); i++) ram_mem[i] = '0;
   end

   always @(posedge clock) begin
      if (bus.ram_wren) ram_mem[bus.ram_waddr] <= bus.ram_data;
      bus.ram_q <= ram_mem[bus.ram_raddr];
      cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   function automatic int pick(input logic [1:0] req, input int prio, input logic [1:0] blk);
      for (int k = 0; k < 2; k++) begin
         int t;
         t = (prio + k) % 2;
         if (req[t] && !blk[t]) return t;
      end
      return -1;
   endfunction

   // Reference: round-robin by priority order, writes first, reads blocked on same-address write.
   always @(negedge clock) begin
      int           wt, rt, wg, rg0, rg1, rg;
      logic [1:0]   blk, ew, er;
      logic [W-1:0] wd;
      if (reset) begin
         check("w_gnt_rst", W'(bus.w_gnt), '0);
         check("r_gnt_rst", W'(bus.r_gnt), '0);
         check("wren_rst", W'(bus.ram_wren), '0);
         m_rprio = 0;
         m_wprio = 0;
      end else begin
         wt  = pick(bus.w_req, m_wprio, 2'b00);
         wg  = (wt == 1) ? HALF + int'(bus.w_addr1) : int'(bus.w_addr0);
         wd  = (wt == 1) ? bus.w_data1 : bus.w_data0;
         rg0 = int'(bus.r_addr0);
         rg1 = HALF + int'(bus.r_addr1);
         blk[0] = (wt >= 0) && (rg0 == wg);
         blk[1] = (wt >= 0) && (rg1 == wg);
         rt  = pick(bus.r_req, m_rprio, blk);
         rg  = (rt == 1) ? rg1 : rg0;
         ew  = (wt < 0) ? 2'b00 : (2'b01 << wt);
         er  = (rt < 0) ? 2'b00 : (2'b01 << rt);
         check("w_gnt", W'(bus.w_gnt), W'(ew));
         check("r_gnt", W'(bus.r_gnt), W'(er));
         check("ram_wren", W'(bus.ram_wren), W'(wt >= 0));
         check("ram_waddr", W'(bus.ram_waddr), W'(wg));
         check("ram_data", bus.ram_data, wd);
         check("ram_raddr", W'(bus.ram_raddr), W'(rg));
         if (rt >= 0) begin
            sb.push_back('{due: cyc + 1, thread: rt, data: ref_mem.exists(rg) ? ref_mem[rg] : '0});
            m_rprio = 1 - rt;
         end
         if (wt >= 0) begin
            ref_mem[wg] = wd;
            m_wprio = 1 - wt;
         end
      end
      seen_r = bus.r_gnt;
      seen_w = bus.w_gnt;
   end

   always @(negedge clock) begin
      logic [1:0]   ev;
      logic [W-1:0] ed;
      rsp_t         e;
      #1;
      ev = 2'b00;
      ed = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         if (!reset) begin
            ev = 2'b01 << e.thread;
            ed = e.data;
         end
      end
      check("rsp_valid", W'(bus.rsp_valid), W'(ev));
      if (ev != 2'b00) check("rsp_data", bus.rsp_data, ed);
   end

   task automatic step(input logic rst, input logic [1:0] rr, input int ra0, input int ra1,
                       input logic [1:0] wr, input int wa0, input int wa1,
                       input logic [W-1:0] wd0, input logic [W-1:0] wd1);
      @(posedge clock);
      #2;
      reset       = rst;
      bus.r_req   = rr;
      bus.r_addr0 = (AB-1)'(ra0);
      bus.r_addr1 = (AB-1)'(ra1);
      bus.w_req   = wr;
      bus.w_addr0 = (AB-1)'(wa0);
      bus.w_addr1 = (AB-1)'(wa1);
      bus.w_data0 = wd0;
      bus.w_data1 = wd1;
   endtask

   function automatic logic [W-1:0] rand_data();
      logic [W-1:0] d;
      for (int k = 0; k < W / 32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic int rand_local();
      return $urandom_range(0, 7) + (($urandom_range(0, 3) == 0) ? 'h100 : 0);
   endfunction

   initial begin
      logic [W-1:0] a5, nd;
      a5 = {32{8'hA5}};
      nd = {8{32'hDEADBEEF}};
      bus.r_req = 2'b11; bus.w_req = 2'b11;
      bus.r_addr0 = '0; bus.r_addr1 = '0; bus.w_addr0 = '0; bus.w_addr1 = '0;
      bus.w_data0 = '0; bus.w_data1 = '0;
      repeat (3) step(1'b1, 2'b11, 1, 2, 2'b11, 0, 3, W'(1), W'(2));
      step(1'b0, 2'b11, 1, 2, 2'b11, 0, 3, W'(1), W'(2));
      step(1'b0, 2'b00, 0, 0, 2'b10, 0, 'h005, '0, a5);
      step(1'b0, 2'b10, 0, 'h005, 2'b00, 0, 0, '0, '0);
      step(1'b0, 2'b01, 'h010, 0, 2'b01, 'h010, 0, nd, '0);
      step(1'b0, 2'b01, 'h010, 0, 2'b00, 0, 0, '0, '0);
      step(1'b0, 2'b10, 0, 'h100, 2'b00, 0, 0, '0, '0);
      step(1'b0, 2'b11, 'h020, 'h100, 2'b01, 'h020, 0, nd, '0);
      step(1'b0, 2'b01, 'h020, 0, 2'b00, 0, 0, '0, '0);
      step(1'b0, 2'b01, 'h005, 0, 2'b00, 0, 0, '0, '0);
      step(1'b1, 2'b11, 'h005, 'h005, 2'b00, 0, 0, '0, '0);
      step(1'b0, 2'b00, 0, 0, 2'b00, 0, 0, '0, '0);
      for (int n = 0; n < 3000; n++) begin
         logic [1:0]   rr, wr;
         int           ra[2], wa[2];
         logic [W-1:0] wd[2];
         ra[0] = int'(bus.r_addr0); ra[1] = int'(bus.r_addr1);
         wa[0] = int'(bus.w_addr0); wa[1] = int'(bus.w_addr1);
         wd[0] = bus.w_data0;       wd[1] = bus.w_data1;
         for (int t = 0; t < 2; t++) begin
            if (bus.r_req[t] && !seen_r[t] && $urandom_range(0, 15) != 0) begin
               rr[t] = 1'b1;
            end else begin
               rr[t] = 1'($urandom_range(0, 1));
               ra[t] = rand_local();
            end
            if (bus.w_req[t] && !seen_w[t] && $urandom_range(0, 15) != 0) begin
               wr[t] = 1'b1;
            end else begin
               wr[t] = 1'($urandom_range(0, 1));
               wa[t] = rand_local();
               wd[t] = rand_data();
            end
         end
         step(($urandom_range(0, 199) == 0), rr, ra[0], ra[1], wr, wa[0], wa[1], wd[0], wd[1]);
      end
      repeat (3) step(1'b0, 2'b00, 0, 0, 2'b00, 0, 0, '0, '0);
      @(negedge clock);
      #2;
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
